// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param: word, parity flag and valid/ready.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_perr;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_perr,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_perr,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, 3-sample majority per bit, optional parity,
// 1/2 stop bits, one-entry holding register with valid/ready and error pulses.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_serial,
    uart_rx_param_if.master bus,
    output logic            frame_err,
    output logic            overrun,
    output logic            rx_busy
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned MID   = CLKS_PER_BIT / 2;
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] C_SMP0 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] C_SMP1 = CNT_W'(MID);
    localparam logic [CNT_W-1:0] C_DEC  = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [1:0]             r_smp;
    logic [BIT_W-1:0]       r_bit_idx;
    logic                   r_stop_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr_pend;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_ovr;

    logic w_rs;
    logic w_maj;
    logic w_dec;

    assign w_rs  = r_sync[SYNC_STAGES-1];
    assign w_maj = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rs) | (r_smp[1] & w_rs);
    assign w_dec = (r_cnt == C_DEC);

    // Line synchroniser; resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_serial};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_smp       <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_perr_pend <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;

            // Bit-period counter runs free from the start edge, wrapping every CLKS_PER_BIT.
            if ((r_state == S_IDLE) || (r_cnt == C_LAST)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_cnt == C_SMP0) r_smp[0] <= w_rs;
            if (r_cnt == C_SMP1) r_smp[1] <= w_rs;

            if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rs) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_dec) begin
                        if (!w_maj) begin
                            r_state     <= S_DATA;
                            r_bit_idx   <= '0;
                            r_perr_pend <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (w_dec) begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            r_stop_idx <= 1'b0;
                            r_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_dec) begin
                        r_perr_pend <= ((^r_shift) ^ w_maj) != (PARITY == 1);
                        r_state     <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_dec) begin
                        if (!w_maj) begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end else if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                            r_state <= S_IDLE;
                            // Same-cycle handshake frees the register; otherwise a full register drops the word.
                            if (r_valid && !bus.rx_ready) begin
                                r_ovr <= 1'b1;
                            end else begin
                                r_data  <= r_shift;
                                r_perr  <= r_perr_pend;
                                r_valid <= 1'b1;
                            end
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (w_rs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_data  = r_data;
    assign bus.rx_valid = r_valid;
    assign bus.rx_perr  = r_perr;
    assign frame_err    = r_ferr;
    assign overrun      = r_ovr;
    assign rx_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) at 16 clocks/bit.
module tb_uart_rx_param;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic ser_a = 1'b1, ser_b = 1'b1, ser_c = 1'b1;
    logic fe_a, ov_a, bz_a, fe_b, ov_b, bz_b, fe_c, ov_c, bz_c;

    uart_rx_param_if #(.DATA_BITS(8)) a_if ();
    uart_rx_param_if #(.DATA_BITS(8)) b_if ();
    uart_rx_param_if #(.DATA_BITS(7)) c_if ();

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .rx_serial(ser_a), .bus(a_if),
        .frame_err(fe_a), .overrun(ov_a), .rx_busy(bz_a));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .rx_serial(ser_b), .bus(b_if),
        .frame_err(fe_b), .overrun(ov_b), .rx_busy(bz_b));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2)) u_c (
        .clk(clk), .rst(rst), .rx_serial(ser_c), .bus(c_if),
        .frame_err(fe_c), .overrun(ov_c), .rx_busy(bz_c));

    // Handshake / pulse monitor, sampled on the falling edge.
    int         words [3];
    int         ferrs [3];
    int         ovrs  [3];
    logic [8:0] ldata [3];
    logic       lperr [3];

    always @(negedge clk) begin
        if (a_if.rx_valid && a_if.rx_ready) begin words[0]++; ldata[0] = 9'(a_if.rx_data); lperr[0] = a_if.rx_perr; end
        if (b_if.rx_valid && b_if.rx_ready) begin words[1]++; ldata[1] = 9'(b_if.rx_data); lperr[1] = b_if.rx_perr; end
        if (c_if.rx_valid && c_if.rx_ready) begin words[2]++; ldata[2] = 9'(c_if.rx_data); lperr[2] = c_if.rx_perr; end
        if (fe_a) ferrs[0]++;
        if (fe_b) ferrs[1]++;
        if (fe_c) ferrs[2]++;
        if (ov_a) ovrs[0]++;
        if (ov_b) ovrs[1]++;
        if (ov_c) ovrs[2]++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        case (which)
            0:       ser_a = v;
            1:       ser_b = v;
            default: ser_c = v;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One line value per clock; `glitch` inverts the line for that single clock index.
    task automatic send_bits(input int which, input logic [15:0] vec, input int len, input int glitch);
        logic b;
        for (int c = 0; c < len * CPB; c++) begin
            @(posedge clk);
            #1;
            b = vec[c / CPB];
            if (c == glitch) b = ~b;
            set_line(which, b);
        end
    endtask

    task automatic send_frame(input int which, input logic [8:0] d, input logic par,
                              input logic [1:0] stp, input int glitch);
        logic [15:0] vec;
        int          len;
        int          nb;
        nb     = (which == 2) ? 7 : 8;
        vec    = '1;
        vec[0] = 1'b0;
        len    = 1;
        for (int i = 0; i < nb; i++) begin
            vec[len] = d[i];
            len++;
        end
        if (which == 1) begin
            vec[len] = par;
            len++;
        end
        vec[len] = stp[0];
        len++;
        if (which == 2) begin
            vec[len] = stp[1];
            len++;
        end
        send_bits(which, vec, len, glitch);
    endtask

    typedef struct {
        int         which;
        logic [8:0] d;
        logic       par;
        logic [1:0] stp;
        int         glitch;
        int         exp_words;
        logic [8:0] exp_data;
        logic       exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int w0, f0, o0;
        logic [15:0] pv;

        tbl[0]  = '{0, 9'h0A5, 1'b0, 2'b11, -1,  1, 9'h0A5, 1'b0, 0};
        tbl[1]  = '{0, 9'h000, 1'b0, 2'b11, -1,  1, 9'h000, 1'b0, 0};
        tbl[2]  = '{0, 9'h0FF, 1'b0, 2'b11, -1,  1, 9'h0FF, 1'b0, 0};
        tbl[3]  = '{0, 9'h0A5, 1'b0, 2'b11, 3*CPB+9, 1, 9'h0A5, 1'b0, 0};
        tbl[4]  = '{0, 9'h03C, 1'b0, 2'b11, 9,   1, 9'h03C, 1'b0, 0};
        tbl[5]  = '{1, 9'h003, 1'b0, 2'b11, -1,  1, 9'h003, 1'b0, 0};
        tbl[6]  = '{1, 9'h003, 1'b1, 2'b11, -1,  1, 9'h003, 1'b1, 0};
        tbl[7]  = '{1, 9'h080, 1'b1, 2'b11, -1,  1, 9'h080, 1'b0, 0};
        tbl[8]  = '{1, 9'h080, 1'b0, 2'b11, -1,  1, 9'h080, 1'b1, 0};
        tbl[9]  = '{1, 9'h05A, 1'b0, 2'b11, -1,  1, 9'h05A, 1'b0, 0};
        tbl[10] = '{2, 9'h055, 1'b0, 2'b11, -1,  1, 9'h055, 1'b0, 0};
        tbl[11] = '{2, 9'h02A, 1'b0, 2'b11, -1,  1, 9'h02A, 1'b0, 0};

        a_if.rx_ready = 1'b1;
        b_if.rx_ready = 1'b1;
        c_if.rx_ready = 1'b1;

        // Reset state
        tick(3);
        chk("rst_data_a",  32'(a_if.rx_data),  0);
        chk("rst_valid_a", 32'(a_if.rx_valid), 0);
        chk("rst_perr_a",  32'(a_if.rx_perr),  0);
        chk("rst_fe_a",    32'(fe_a), 0);
        chk("rst_ov_a",    32'(ov_a), 0);
        chk("rst_busy_a",  32'(bz_a), 0);
        chk("rst_valid_b", 32'(b_if.rx_valid), 0);
        chk("rst_valid_c", 32'(c_if.rx_valid), 0);
        rst = 1'b0;
        tick(5);

        // Table of clean and glitched frames across the three configurations
        for (int i = 0; i < 12; i++) begin
            w0 = words[tbl[i].which];
            f0 = ferrs[tbl[i].which];
            o0 = ovrs[tbl[i].which];
            send_frame(tbl[i].which, tbl[i].d, tbl[i].par, tbl[i].stp, tbl[i].glitch);
            tick(20);
            chk($sformatf("v%0d_words", i), 32'(words[tbl[i].which] - w0), 32'(tbl[i].exp_words));
            chk($sformatf("v%0d_ferr", i),  32'(ferrs[tbl[i].which] - f0), 32'(tbl[i].exp_ferr));
            chk($sformatf("v%0d_ovr", i),   32'(ovrs[tbl[i].which] - o0),  0);
            if (tbl[i].exp_words > 0) begin
                chk($sformatf("v%0d_data", i), 32'(ldata[tbl[i].which]), 32'(tbl[i].exp_data));
                chk($sformatf("v%0d_perr", i), 32'(lperr[tbl[i].which]), 32'(tbl[i].exp_perr));
            end
        end

        // 7N2: second stop low -> framing error, hold in BREAK until line returns high
        w0 = words[2];
        f0 = ferrs[2];
        send_frame(2, 9'h055, 1'b0, 2'b01, -1);
        tick(40);
        chk("brk_ferr",  32'(ferrs[2] - f0), 1);
        chk("brk_words", 32'(words[2] - w0), 0);
        chk("brk_valid", 32'(c_if.rx_valid), 0);
        chk("brk_busy",  32'(bz_c), 1);
        set_line(2, 1'b1);
        tick(6);
        chk("brk_idle",  32'(bz_c), 0);
        send_frame(2, 9'h02A, 1'b0, 2'b11, -1);
        tick(20);
        chk("brk_next_words", 32'(words[2] - w0), 1);
        chk("brk_next_data",  32'(ldata[2]), 32'h2A);

        // Overrun: consumer stalled, two back-to-back frames
        a_if.rx_ready = 1'b0;
        w0 = words[0];
        f0 = ferrs[0];
        o0 = ovrs[0];
        send_frame(0, 9'h011, 1'b0, 2'b11, -1);
        send_frame(0, 9'h022, 1'b0, 2'b11, -1);
        tick(10);
        chk("ovr_valid", 32'(a_if.rx_valid), 1);
        chk("ovr_data",  32'(a_if.rx_data), 32'h11);
        chk("ovr_pulse", 32'(ovrs[0] - o0), 1);
        chk("ovr_ferr",  32'(ferrs[0] - f0), 0);
        a_if.rx_ready = 1'b1;
        tick(3);
        chk("ovr_words", 32'(words[0] - w0), 1);
        chk("ovr_ldata", 32'(ldata[0]), 32'h11);
        chk("ovr_drop",  32'(a_if.rx_valid), 0);
        tick(40);
        chk("ovr_no22",  32'(words[0] - w0), 1);

        // Idle-line glitches: 1-clock and 6-clock lows are false starts
        w0 = words[0];
        f0 = ferrs[0];
        set_line(0, 1'b0);
        tick(1);
        set_line(0, 1'b1);
        tick(30);
        chk("g1_ferr",  32'(ferrs[0] - f0), 1);
        chk("g1_words", 32'(words[0] - w0), 0);
        chk("g1_fe_low", 32'(fe_a), 0);
        chk("g1_busy",  32'(bz_a), 0);
        f0 = ferrs[0];
        set_line(0, 1'b0);
        tick(6);
        set_line(0, 1'b1);
        tick(30);
        chk("g6_ferr",  32'(ferrs[0] - f0), 1);
        chk("g6_words", 32'(words[0] - w0), 0);
        chk("g6_busy",  32'(bz_a), 0);

        // Reset in the middle of DATA for 0xFF
        pv = 16'hFFFE;
        send_bits(0, pv, 4, -1);
        chk("mid_busy", 32'(bz_a), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_data",  32'(a_if.rx_data),  0);
        chk("mid_rst_valid", 32'(a_if.rx_valid), 0);
        chk("mid_rst_perr",  32'(a_if.rx_perr),  0);
        chk("mid_rst_busy",  32'(bz_a), 0);
        chk("mid_rst_fe",    32'(fe_a), 0);
        tick(3);
        rst = 1'b0;
        tick(3);
        w0 = words[0];
        f0 = ferrs[0];
        send_frame(0, 9'h03C, 1'b0, 2'b11, -1);
        tick(20);
        chk("post_rst_words", 32'(words[0] - w0), 1);
        chk("post_rst_data",  32'(ldata[0]), 32'h3C);
        chk("post_rst_ferr",  32'(ferrs[0] - f0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver; successor to the fixed 8N1 receiver. Supports configurable data width, parity and stop-bit count, with 3-sample majority voting and an input synchroniser. Output is a one-entry holding register with a valid/ready handshake, plus error reporting (parity, framing, overrun). Sits between the board RX pin and the command/packet logic.

Parameters:
CLKS_PER_BIT, 868, clocks per bit period (115200 baud at 100 MHz); legal range 8..65535
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 2, synchroniser flops on rx_serial, minimum 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx_serial  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received word; stable while rx_valid=1
rx_valid  out  1  rx_data holds an unconsumed word
rx_ready  in  1  consumer accepts word when rx_valid&rx_ready at posedge clk
rx_perr  out  1  parity error for the word in rx_data; qualified by rx_valid
frame_err  out  1  1-cycle pulse: bad stop bit or false start
overrun  out  1  1-cycle pulse: completed word dropped because holding register full
rx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): synchroniser flops = 1; FSM = IDLE; rx_data = 0; rx_valid, rx_perr, frame_err, overrun, rx_busy = 0; counters = 0.
- Reset mid-frame aborts the frame immediately; no partial word is ever presented.
- Synchronised line rs = rx_serial after SYNC_STAGES clocks. Bit counter width = $clog2(CLKS_PER_BIT).
- Sampling: a bit value is the majority of rs at counter = M-1, M, M+1, where M = CLKS_PER_BIT/2 (integer divide). The bit period is exactly CLKS_PER_BIT clocks, measured from the start-bit falling edge.
- IDLE: on rs = 0, go to START with counter = 0.
- START: at counter M+1, if the majority is 0, go to DATA. Otherwise pulse frame_err (false start) and return to IDLE.
- DATA: capture DATA_BITS bits LSB first, one per bit period at the mid-bit majority. After the last bit, go to PARITY if PARITY != 0, else STOP.
- PARITY: sample one bit. perr = (XOR of data bits ^ parity bit) != expected, where expected XOR of all bits is 1 for odd and 0 for even.
- STOP: sample STOP_BITS bits. Any stop sample = 0 -> frame_err pulse, word discarded, go to BREAK.
- BREAK: wait for rs = 1, then go to IDLE.
- On valid stop(s), the word completes at the final stop sample point and the FSM returns to IDLE that cycle. Return happens at mid-stop, so a back-to-back start bit is caught.
- Completion with holding register free: load rx_data and rx_perr; rx_valid = 1 on the next cycle. Latency from the final stop sample to rx_valid is 1 clk.
- Completion while rx_valid=1 and rx_ready=0: pulse overrun; old word is retained; new word is dropped.
- Completion in the same cycle as rx_valid&rx_ready: the handshake frees the register, the new word loads, rx_valid stays 1, and there is no overrun.
- Handshake with no completion: rx_valid = 0 on the next cycle. rx_data and rx_perr hold their last value.
- rx_valid never drops without a handshake or reset.
- frame_err and overrun cannot both fire for the same frame.
- rx_busy = 1 in every state except IDLE.

Test Plan:
- CLKS_PER_BIT=16, 8N1, rx_ready=1: send 0xA5 -> rx_data=0xA5, rx_valid high 1 cycle, rx_perr=0, no error pulses.
- PARITY=2 (even), 8E1: send 0x03 with parity bit 0 -> rx_data=0x03, rx_perr=0. Send 0x03 with parity bit 1 -> rx_perr=1 with rx_valid.
- DATA_BITS=7, STOP_BITS=2: send 0x55 with second stop bit forced 0 -> frame_err pulse, rx_valid stays 0; FSM waits in BREAK until the line goes high, then receives 0x2A correctly.
- rx_ready=0: send 0x11 then 0x22 back to back -> rx_data=0x11 held, one overrun pulse at the 0x22 stop sample. Assert rx_ready -> rx_valid drops, no 0x22 delivered.
- Glitch: 1-clock low pulse on an idle line -> no valid and frame_err not stuck. A 6-clock low pulse (less than M=8) -> frame_err false-start pulse and return to IDLE. A single-clock inverted glitch at mid-bit of a data bit -> majority rejects it and the word is correct.
- Assert rst during DATA of 0xFF -> all outputs 0 immediately. After release, send 0x3C -> rx_data=0x3C, no stale bits.
